// File: rtl/axi2per_bridge.sv
// AXI4 slave to 32-bit peripheral master: one AXI burst at a time, split into single-word peripheral accesses.
// Read latency AR->R is 3 cycles minimum; R/B are held until accepted and W beats are consumed on peripheral grant.
module axi2per_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 6,
    parameter int PER_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_en_i,
    input  logic                      axi_slave_aw_valid_i,
    output logic                      axi_slave_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr_i,
    input  logic [7:0]                axi_slave_aw_len_i,
    input  logic [2:0]                axi_slave_aw_size_i,
    input  logic [1:0]                axi_slave_aw_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_slave_aw_user_i,
    input  logic                      axi_slave_ar_valid_i,
    output logic                      axi_slave_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr_i,
    input  logic [7:0]                axi_slave_ar_len_i,
    input  logic [2:0]                axi_slave_ar_size_i,
    input  logic [1:0]                axi_slave_ar_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_slave_ar_user_i,
    input  logic                      axi_slave_w_valid_i,
    output logic                      axi_slave_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] axi_slave_w_data_i,
    input  logic [7:0]                axi_slave_w_strb_i,
    input  logic                      axi_slave_w_last_i,
    output logic                      axi_slave_b_valid_o,
    input  logic                      axi_slave_b_ready_i,
    output logic [1:0]                axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
    output logic                      axi_slave_r_valid_o,
    input  logic                      axi_slave_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
    output logic [1:0]                axi_slave_r_resp_o,
    output logic                      axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
    output logic                      per_master_req_o,
    output logic [AXI_ADDR_WIDTH-1:0] per_master_add_o,
    output logic                      per_master_wen_o,
    output logic [PER_DATA_WIDTH-1:0] per_master_wdata_o,
    output logic [3:0]                per_master_be_o,
    input  logic                      per_master_gnt_i,
    input  logic                      per_master_r_valid_i,
    input  logic                      per_master_r_opc_i,
    input  logic [PER_DATA_WIDTH-1:0] per_master_r_rdata_i,
    output logic                      busy_o
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP} state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, next_addr;
    logic [7:0]                len_q, beat_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_USER_WIDTH-1:0] user_q;
    logic                      err_q, prio_rd_q, rd_win, bad_size, last_beat, err_next;
    logic                      unused_ok;

    assign unused_ok = ^{test_en_i, axi_slave_w_last_i};

    assign rd_win    = axi_slave_ar_valid_i && (!axi_slave_aw_valid_i || prio_rd_q);
    assign axi_slave_ar_ready_o = (state == IDLE) && rd_win;
    assign axi_slave_aw_ready_o = (state == IDLE) && axi_slave_aw_valid_i && !rd_win;
    // Oversized beats never reach the peripheral, so W is drained directly from WR_DATA.
    assign axi_slave_w_ready_o  = ((state == WR_REQ) && per_master_gnt_i) || ((state == WR_DATA) && bad_size);

    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);
    assign bad_size  = size_q > 3'd2;
    assign last_beat = beat_q == len_q;
    assign err_next  = err_q | per_master_r_opc_i;
    assign busy_o    = state != IDLE;
    assign axi_slave_b_id_o   = id_q;
    assign axi_slave_b_user_o = user_q;
    assign axi_slave_r_id_o   = id_q;
    assign axi_slave_r_user_o = user_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            addr_q <= '0; len_q <= '0; beat_q <= '0; size_q <= '0; burst_q <= '0;
            id_q <= '0; user_q <= '0; err_q <= 1'b0; prio_rd_q <= 1'b1;
            axi_slave_b_valid_o <= 1'b0; axi_slave_b_resp_o <= RESP_OKAY;
            axi_slave_r_valid_o <= 1'b0; axi_slave_r_data_o <= '0;
            axi_slave_r_resp_o <= RESP_OKAY; axi_slave_r_last_o <= 1'b0;
            per_master_req_o <= 1'b0; per_master_add_o <= '0; per_master_wen_o <= 1'b0;
            per_master_wdata_o <= '0; per_master_be_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (axi_slave_ar_ready_o) begin
                        addr_q <= axi_slave_ar_addr_i; len_q <= axi_slave_ar_len_i;
                        size_q <= axi_slave_ar_size_i; burst_q <= axi_slave_ar_burst_i;
                        id_q <= axi_slave_ar_id_i; user_q <= axi_slave_ar_user_i;
                        beat_q <= '0; err_q <= 1'b0;
                        if (axi_slave_aw_valid_i) prio_rd_q <= 1'b0;
                        per_master_req_o <= axi_slave_ar_size_i <= 3'd2;
                        per_master_wen_o <= 1'b1;
                        per_master_be_o  <= 4'hF;
                        per_master_add_o <= {axi_slave_ar_addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
                        state <= RD_REQ;
                    end else if (axi_slave_aw_ready_o) begin
                        addr_q <= axi_slave_aw_addr_i; len_q <= axi_slave_aw_len_i;
                        size_q <= axi_slave_aw_size_i; burst_q <= axi_slave_aw_burst_i;
                        id_q <= axi_slave_aw_id_i; user_q <= axi_slave_aw_user_i;
                        beat_q <= '0; err_q <= 1'b0;
                        if (axi_slave_ar_valid_i) prio_rd_q <= 1'b1;
                        state <= WR_DATA;
                    end
                end
                RD_REQ: begin
                    if (bad_size) begin
                        axi_slave_r_valid_o <= 1'b1;
                        axi_slave_r_data_o  <= '0;
                        axi_slave_r_resp_o  <= RESP_SLVERR;
                        axi_slave_r_last_o  <= last_beat;
                        state <= RD_RESP;
                    end else if (per_master_gnt_i) begin
                        per_master_req_o <= 1'b0;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (per_master_r_valid_i) begin
                        axi_slave_r_valid_o <= 1'b1;
                        axi_slave_r_data_o  <= {2{per_master_r_rdata_i}};
                        axi_slave_r_resp_o  <= per_master_r_opc_i ? RESP_SLVERR : RESP_OKAY;
                        axi_slave_r_last_o  <= last_beat;
                        state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi_slave_r_ready_i) begin
                        axi_slave_r_valid_o <= 1'b0;
                        axi_slave_r_last_o  <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                            per_master_req_o <= !bad_size;
                            per_master_add_o <= {next_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
                            state <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (axi_slave_w_valid_i) begin
                        if (bad_size) begin
                            err_q <= 1'b1;
                            if (last_beat) begin
                                axi_slave_b_valid_o <= 1'b1;
                                axi_slave_b_resp_o  <= RESP_SLVERR;
                                state <= WR_RESP;
                            end else begin
                                addr_q <= next_addr;
                                beat_q <= beat_q + 8'd1;
                            end
                        end else begin
                            per_master_req_o   <= 1'b1;
                            per_master_wen_o   <= 1'b0;
                            per_master_add_o   <= {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
                            per_master_wdata_o <= addr_q[2] ? axi_slave_w_data_i[63:32] : axi_slave_w_data_i[31:0];
                            per_master_be_o    <= addr_q[2] ? axi_slave_w_strb_i[7:4] : axi_slave_w_strb_i[3:0];
                            state <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (per_master_gnt_i) begin
                        per_master_req_o <= 1'b0;
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (per_master_r_valid_i) begin
                        err_q <= err_next;
                        if (last_beat) begin
                            axi_slave_b_valid_o <= 1'b1;
                            axi_slave_b_resp_o  <= err_next ? RESP_SLVERR : RESP_OKAY;
                            state <= WR_RESP;
                        end else begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                            state <= WR_DATA;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_slave_b_ready_i) begin
                        axi_slave_b_valid_o <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
